// File: rtl/demux_pkg.sv
// ============================================================================
// Module : demux_pkg
// Shared types and sizing for the 3-to-8 demux arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_pkg;

    localparam int SEL_W = 3;
    localparam int N_REQ = 2 ** SEL_W;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/demux_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Combinational round-robin picker: first set request at or after ptr+1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import demux_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             ptr,
    output sel_t             winner,
    output logic             valid
);

    // Walk the rotated vector from the far end so the lowest rotated
    // position (closest to ptr+1) overwrites last and wins.
    always_comb begin
        sel_t start;
        sel_t cand;
        start  = ptr + sel_t'(1);
        cand   = start;
        winner = start;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = start + sel_t'(i);
            if (req[cand]) begin
                winner = cand;
            end
        end
        valid = |req;
    end

endmodule

`default_nettype wire

// File: rtl/demux_arbiter.sv
// ============================================================================
// Module : demux_arbiter
// Round-robin arbiter/sequencer driving the select and enable of a 3-to-8 demux.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_arbiter
    import demux_pkg::*;
#(
    parameter int MAX_HOLD = 15
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             e,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             timeout
);

    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

    arb_state_t       state_q, state_d;
    sel_t             idx_q, idx_d;
    sel_t             ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             e_q, e_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    sel_t             w_pick_idx;
    logic             w_pick_valid;
    logic             w_rel_done;
    logic             w_rel_withdraw;
    logic             w_rel_limit;

    rr_pick u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (w_pick_idx),
        .valid  (w_pick_valid)
    );

    assign w_rel_done     = done;
    assign w_rel_withdraw = ~req[idx_q];
    assign w_rel_limit    = (cnt_q == c_max_hold);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        e_d       = e_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                e_d    = 1'b0;
                busy_d = 1'b0;
                gnt_d  = '0;
                if (w_pick_valid) begin
                    state_d = GRANT;
                    idx_d   = w_pick_idx;
                    ptr_d   = w_pick_idx;
                    cnt_d   = 8'd1;
                    e_d     = 1'b1;
                    busy_d  = 1'b1;
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
                end
            end
            GRANT: begin
                if (w_rel_done || w_rel_withdraw || w_rel_limit) begin
                    // Select bits stay on the last index; only enable drops.
                    state_d   = IDLE;
                    e_d       = 1'b0;
                    busy_d    = 1'b0;
                    gnt_d     = '0;
                    timeout_d = ~w_rel_done & ~w_rel_withdraw;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                e_d     = 1'b0;
                busy_d  = 1'b0;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ptr_q     <= sel_t'(N_REQ - 1);
            cnt_q     <= '0;
            e_q       <= 1'b0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            e_q       <= e_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign a       = idx_q[SEL_W-1];
    assign b       = idx_q[1];
    assign c       = idx_q[0];
    assign e       = e_q;
    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_arbiter.sv
// ============================================================================
// Module : tb_demux_arbiter
// Scenario-driven bench for demux_arbiter with an expected-grant queue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_arbiter;

    localparam int MAX_HOLD = 15;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] abc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       a, b, c, e, busy, timeout;
    logic [7:0] gnt;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    demux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .a       (a),
        .b       (b),
        .c       (c),
        .e       (e),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Advances until e is high; reports how many edges it took.
    task automatic wait_grant(input int max_cyc, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        while (cyc < max_cyc) begin
            tick();
            cyc++;
            if (e === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        #3;
        n_cmp++; if ({a, b, c, e, busy, timeout} !== 6'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 000000", {a, b, c, e, busy, timeout}); end
        n_cmp++; if (gnt !== 8'h00) begin n_err++; $display("FAIL reset_gnt: got %h want 00", gnt); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL reset_idle_e: got %b want 0", e); end
    endtask

    task automatic test_single();
        exp_t ex;
        bit   ok;
        int   cyc;
        do_reset();
        req = 8'h01;
        sb.push_back('{gnt: 8'h01, abc: 3'b000});
        tick();
        ex = sb.pop_front();
        n_cmp++; if (gnt !== ex.gnt || {a, b, c} !== ex.abc || e !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL single_grant: got gnt=%h abc=%b e=%b busy=%b want gnt=%h abc=%b e=1 busy=1", gnt, {a, b, c}, e, busy, ex.gnt, ex.abc); end
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++; if (e !== 1'b0 || gnt !== 8'h00 || busy !== 1'b0 || {a, b, c} !== 3'b000) begin n_err++; $display("FAIL single_release: got e=%b gnt=%h busy=%b abc=%b want e=0 gnt=00 busy=0 abc=000", e, gnt, busy, {a, b, c}); end
        sb.push_back('{gnt: 8'h01, abc: 3'b000});
        wait_grant(4, ok, cyc);
        ex = sb.pop_front();
        n_cmp++; if (!ok || cyc != 1 || gnt !== ex.gnt) begin n_err++; $display("FAIL single_regrant: got ok=%0d cyc=%0d gnt=%h want ok=1 cyc=1 gnt=%h", ok, cyc, gnt, ex.gnt); end
        req = '0;
        tick();
        n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL single_withdraw: got e=%b want 0", e); end
    endtask

    task automatic test_round_robin();
        exp_t ex;
        bit   ok;
        int   cyc;
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            sb.push_back('{gnt: 8'(1 << (i % 8)), abc: 3'(i % 8)});
        end
        for (int i = 0; i < 9; i++) begin
            wait_grant(4, ok, cyc);
            ex = sb.pop_front();
            n_cmp++; if (!ok || cyc != 1 || gnt !== ex.gnt || {a, b, c} !== ex.abc) begin n_err++; $display("FAIL rr_grant[%0d]: got ok=%0d cyc=%0d gnt=%h abc=%b want cyc=1 gnt=%h abc=%b", i, ok, cyc, gnt, {a, b, c}, ex.gnt, ex.abc); end
            done = 1'b1;
            tick();
            done = 1'b0;
            n_cmp++; if (e !== 1'b0 || gnt !== 8'h00) begin n_err++; $display("FAIL rr_gap[%0d]: got e=%b gnt=%h want e=0 gnt=00", i, e, gnt); end
        end
        req = '0;
        tick();
    endtask

    task automatic test_timeout();
        exp_t ex;
        bit   ok;
        int   cyc;
        int   held;
        do_reset();
        req = 8'h20;
        sb.push_back('{gnt: 8'h20, abc: 3'b101});
        wait_grant(4, ok, cyc);
        ex = sb.pop_front();
        n_cmp++; if (!ok || gnt !== ex.gnt || {a, b, c} !== ex.abc) begin n_err++; $display("FAIL to_grant: got ok=%0d gnt=%h abc=%b want gnt=%h abc=%b", ok, gnt, {a, b, c}, ex.gnt, ex.abc); end
        held = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (e !== 1'b1) break;
            held++;
        end
        n_cmp++; if (held != MAX_HOLD) begin n_err++; $display("FAIL to_hold: got %0d cycles want %0d", held, MAX_HOLD); end
        n_cmp++; if (timeout !== 1'b1 || e !== 1'b0) begin n_err++; $display("FAIL to_pulse: got timeout=%b e=%b want timeout=1 e=0", timeout, e); end
        sb.push_back('{gnt: 8'h20, abc: 3'b101});
        tick();
        ex = sb.pop_front();
        n_cmp++; if (timeout !== 1'b0 || e !== 1'b1 || gnt !== ex.gnt || {a, b, c} !== ex.abc) begin n_err++; $display("FAIL to_regrant: got timeout=%b e=%b gnt=%h abc=%b want timeout=0 e=1 gnt=%h abc=%b", timeout, e, gnt, {a, b, c}, ex.gnt, ex.abc); end
        req = '0;
        tick();
        n_cmp++; if (timeout !== 1'b0 || e !== 1'b0) begin n_err++; $display("FAIL to_withdraw: got timeout=%b e=%b want 0 0", timeout, e); end
    endtask

    task automatic test_withdraw();
        exp_t ex;
        bit   ok;
        int   cyc;
        do_reset();
        req = 8'h04;
        sb.push_back('{gnt: 8'h04, abc: 3'b010});
        wait_grant(4, ok, cyc);
        ex = sb.pop_front();
        n_cmp++; if (!ok || gnt !== ex.gnt || {a, b, c} !== ex.abc) begin n_err++; $display("FAIL wd_grant: got ok=%0d gnt=%h abc=%b want gnt=%h abc=%b", ok, gnt, {a, b, c}, ex.gnt, ex.abc); end
        tick();
        req = 8'h40;
        tick();
        n_cmp++; if (e !== 1'b0 || {a, b, c} !== 3'b010 || timeout !== 1'b0) begin n_err++; $display("FAIL wd_release: got e=%b abc=%b timeout=%b want e=0 abc=010 timeout=0", e, {a, b, c}, timeout); end
        sb.push_back('{gnt: 8'h40, abc: 3'b110});
        wait_grant(4, ok, cyc);
        ex = sb.pop_front();
        n_cmp++; if (!ok || cyc != 1 || gnt !== ex.gnt || {a, b, c} !== ex.abc) begin n_err++; $display("FAIL wd_next: got ok=%0d cyc=%0d gnt=%h abc=%b want cyc=1 gnt=%h abc=%b", ok, cyc, gnt, {a, b, c}, ex.gnt, ex.abc); end
        req = '0;
        tick();
    endtask

    task automatic test_done_at_max();
        exp_t ex;
        bit   ok;
        int   cyc;
        do_reset();
        req = 8'h01;
        sb.push_back('{gnt: 8'h01, abc: 3'b000});
        wait_grant(4, ok, cyc);
        ex = sb.pop_front();
        n_cmp++; if (!ok || gnt !== ex.gnt) begin n_err++; $display("FAIL dm_grant: got ok=%0d gnt=%h want %h", ok, gnt, ex.gnt); end
        for (int i = 0; i < MAX_HOLD - 1; i++) tick();
        n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL dm_still_held: got e=%b want 1", e); end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++; if (e !== 1'b0 || timeout !== 1'b0) begin n_err++; $display("FAIL dm_release: got e=%b timeout=%b want e=0 timeout=0", e, timeout); end
        req = '0;
        tick();
    endtask

    task automatic test_async_reset();
        exp_t ex;
        bit   ok;
        int   cyc;
        do_reset();
        req = 8'h08;
        sb.push_back('{gnt: 8'h08, abc: 3'b011});
        wait_grant(4, ok, cyc);
        ex = sb.pop_front();
        n_cmp++; if (!ok || gnt !== ex.gnt || {a, b, c} !== ex.abc) begin n_err++; $display("FAIL ar_grant: got ok=%0d gnt=%h abc=%b want gnt=%h abc=%b", ok, gnt, {a, b, c}, ex.gnt, ex.abc); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (e !== 1'b0 || gnt !== 8'h00 || busy !== 1'b0) begin n_err++; $display("FAIL ar_async: got e=%b gnt=%h busy=%b want 0 00 0", e, gnt, busy); end
        tick();
        req   = 8'h09;
        rst_n = 1'b1;
        sb.push_back('{gnt: 8'h01, abc: 3'b000});
        wait_grant(4, ok, cyc);
        ex = sb.pop_front();
        n_cmp++; if (!ok || gnt !== ex.gnt || {a, b, c} !== ex.abc) begin n_err++; $display("FAIL ar_first: got ok=%0d gnt=%h abc=%b want gnt=%h abc=%b", ok, gnt, {a, b, c}, ex.gnt, ex.abc); end
        done = 1'b1;
        tick();
        done = 1'b0;
        sb.push_back('{gnt: 8'h08, abc: 3'b011});
        wait_grant(4, ok, cyc);
        ex = sb.pop_front();
        n_cmp++; if (!ok || gnt !== ex.gnt || {a, b, c} !== ex.abc) begin n_err++; $display("FAIL ar_second: got ok=%0d gnt=%h abc=%b want gnt=%h abc=%b", ok, gnt, {a, b, c}, ex.gnt, ex.abc); end
        req = '0;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_withdraw();
        test_done_at_max();
        test_async_reset();
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux_arbiter.md
Name: demux_arbiter

Overview:
- Round-robin arbiter and sequencer for the 3-to-8 demux.
- Shares the demux among 8 requesters. Grants one requester at a time and drives the demux select (a,b,c) and enable (e) so that only the granted output line is active.
- Enforces a per-grant hold limit and a one-cycle idle gap between grants.
- Sits directly in front of the demux instance; its a/b/c/e outputs connect straight to the demux inputs.

Parameters:
- SEL_W, 3, select width; requester count N_REQ = 2**SEL_W = 8.
- MAX_HOLD, 15, maximum cycles a grant may stay active before a forced release (valid range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i = requester i wants the demux.
- done  input  1  current owner finished; sampled only in GRANT.
- a  output  1  demux select MSB (index bit 2).
- b  output  1  demux select bit 1.
- c  output  1  demux select LSB (index bit 0).
- e  output  1  demux enable; 1 only while a grant is active.
- gnt  output  8  one-hot grant; equals the demux output pattern.
- busy  output  1  1 while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = IDLE; a=b=c=0, e=0, gnt=0, busy=0, timeout=0.
  - Hold counter = 0; last-grant pointer = 7, so requester 0 has first priority.
- All outputs are registered. {a,b,c} always equals the registered grant index; gnt = (e ? 1<<idx : 0).
- State IDLE:
  - e=0, busy=0. When req != 0, pick the first set bit searching upward from (ptr+1) mod 8 with wrap-around.
  - On the next edge: idx <= winner, ptr <= winner, counter <= 1, state <= GRANT.
  - Latency: req sampled at edge t gives e=1 and gnt valid after edge t.
- State GRANT:
  - e=1, busy=1, select held constant.
  - Each cycle evaluate in priority order:
    1. done=1 -> release.
    2. req[idx]=0 -> release (requester withdrew).
    3. counter == MAX_HOLD -> release with timeout=1 for exactly the following cycle.
    4. Otherwise counter increments.
  - Release: state <= IDLE; e, gnt, busy go to 0 on that edge. {a,b,c} keep the last index.
- Mandatory gap: after any release, at least one IDLE cycle with e=0. A new grant cannot start on the release edge.
- Simultaneous done and counter==MAX_HOLD: treated as a normal done, timeout=0.
- Other requests arriving during GRANT are ignored until IDLE; no preemption.
- A single persistent requester with no competitors is re-granted after the one-cycle gap.
- Fairness: with all 8 requesting continuously, grant order is 0,1,...,7,0,...
- The counter is 8 bits wide and cannot overflow because of the MAX_HOLD clamp.
- Reset mid-grant immediately forces e=0 and gnt=0 asynchronously; the pointer returns to 7.

Decomposition:
- Shared package demux_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t.
  - localparam SEL_W=3 and N_REQ=8.
  - typedef logic [SEL_W-1:0] sel_t.
- One sub-module: rr_pick. Purely combinational: req + ptr -> winner index and a valid flag, using a rotate-and-priority-encode scheme.
- FSM, counter and output registers live in demux_arbiter.

Test Plan:
- Reset then req=8'b0000_0001, done pulsed on the 3rd grant cycle -> {a,b,c}=000, e=1, gnt=8'h01 one edge after req. Release after done, then e=0 for one cycle.
- req=8'hFF held, done pulsed each grant's first cycle -> grants appear in order 0..7 then 0 again, gnt = 01,02,04,...,80,01, each separated by one e=0 cycle.
- req=8'b0010_0000 held, done=0, MAX_HOLD=15 -> gnt=8'h20 for exactly 15 cycles, then timeout=1 for one cycle with e=0, then re-grant to 5 ({a,b,c}=101).
- Grant to 2 ({a,b,c}=010), then req[2] dropped mid-grant while req[6]=1 -> release on the next edge, one-cycle gap, then gnt=8'h40, {a,b,c}=110.
- done=1 on the same cycle the counter hits MAX_HOLD -> release with timeout remaining 0.
- rst_n asserted low mid-grant to requester 3 -> e, gnt, busy go to 0 immediately. After release with req=8'h09, the first grant goes to 0, not 3.
